// File: rtl/common_pkg.sv
// Shared scalar types for the RV64 pipeline.
package common_pkg;
    typedef logic [63:0] u64;
    typedef logic [31:0] u32;
endpackage

// File: rtl/fetch_stage_pkg.sv
// Pipe types for the IF stage: IF/ID payload, fetch FSM states and PC mux selects.
package fetch_stage_pkg;
    import common_pkg::*;

    localparam u64 PCINIT_DEFAULT = 64'h0000_0000_8000_0000;
    localparam u32 NOP_INSTR      = 32'h0000_0013;

    typedef enum logic [1:0] {IDLE, REQ, HOLD, DRAIN} fetch_state_t;
    typedef enum logic [1:0] {PC_HOLD, PC_INC, PC_REDIR} pc_sel_t;

    typedef struct packed {
        logic valid;
        u64   pc;
        u32   raw_instr;
        logic misalign;
    } fetch_data_t;
endpackage

// File: rtl/fetch_stage_pc_select.sv
// Next-PC mux for the fetch stage: sequential increment, redirect target or hold.
module pc_select
    import common_pkg::*;
    import fetch_stage_pkg::*;
(
    input  pc_sel_t sel_i,
    input  u64      pc_i,
    input  u64      redirect_pc_i,
    output u64      next_pc_o
);
    always_comb begin
        next_pc_o = pc_i;
        case (sel_i)
            PC_INC:   next_pc_o = pc_i + 64'd4;
            PC_REDIR: next_pc_o = redirect_pc_i;
            default:  next_pc_o = pc_i;
        endcase
    end
endmodule

// File: rtl/fetch_stage.sv
// RV64 IF stage: one outstanding instruction-bus request, IF/ID output register, redirect handling.
// Build option FETCH_ALIGN_CHECK_EN turns a misaligned PC into a flagged NOP instead of a bus request.
module fetch_stage
    import common_pkg::*;
    import fetch_stage_pkg::*;
#(
    parameter u64 PCINIT = PCINIT_DEFAULT
)
(
    input  logic        clk,
    input  logic        reset,
    output logic        ireq_valid,
    output logic [63:0] ireq_addr,
    input  logic        iresp_data_ok,
    input  logic [31:0] iresp_data,
    input  logic        redirect_valid,
    input  logic [63:0] redirect_pc,
    input  logic        d_ready,
    output logic        f_valid,
    output logic [63:0] f_pc,
    output logic [31:0] f_raw_instr,
    output logic        f_misalign
);
    fetch_state_t state_q, state_d;
    fetch_data_t  f_q, f_d;
    u64           pc_q, pc_d;
    u64           addr_q, addr_d;
    pc_sel_t      pc_sel;
    logic         misaligned;

`ifdef FETCH_ALIGN_CHECK_EN
    assign misaligned = (pc_q[1:0] != 2'b00);
`else
    assign misaligned = 1'b0;
`endif

    pc_select u_pc_select (
        .sel_i         (pc_sel),
        .pc_i          (pc_q),
        .redirect_pc_i (redirect_pc),
        .next_pc_o     (pc_d)
    );

    always_comb begin
        state_d = state_q;
        f_d     = f_q;
        pc_sel  = PC_HOLD;
        case (state_q)
            IDLE: begin
                state_d = REQ;
                if (redirect_valid) begin
                    pc_sel   = PC_REDIR;
                    f_d.valid = 1'b0;
                end
            end
            REQ: begin
                if (misaligned) begin
                    if (redirect_valid) begin
                        pc_sel = PC_REDIR;
                    end else begin
                        f_d     = '{valid: 1'b1, pc: pc_q, raw_instr: NOP_INSTR, misalign: 1'b1};
                        state_d = HOLD;
                    end
                end else if (redirect_valid) begin
                    // A response arriving with the redirect is simply discarded; otherwise it is still owed.
                    pc_sel  = PC_REDIR;
                    state_d = iresp_data_ok ? REQ : DRAIN;
                end else if (iresp_data_ok) begin
                    f_d     = '{valid: 1'b1, pc: pc_q, raw_instr: iresp_data, misalign: 1'b0};
                    pc_sel  = PC_INC;
                    state_d = HOLD;
                end
            end
            HOLD: begin
                if (redirect_valid) begin
                    pc_sel    = PC_REDIR;
                    f_d.valid = 1'b0;
                    state_d   = REQ;
                end else if (f_q.valid && d_ready) begin
                    f_d.valid = 1'b0;
                    state_d   = REQ;
                end
            end
            DRAIN: begin
                if (redirect_valid) begin
                    pc_sel = PC_REDIR;
                end
                if (iresp_data_ok) begin
                    state_d = REQ;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // The bus address only moves when a new request starts, so DRAIN keeps the old one.
    assign addr_d = (state_d == REQ) ? pc_d : addr_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            pc_q    <= PCINIT;
            addr_q  <= PCINIT;
            f_q     <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            addr_q  <= addr_d;
            f_q     <= f_d;
        end
    end

    assign ireq_valid  = (state_q == DRAIN) || ((state_q == REQ) && !misaligned);
    assign ireq_addr   = addr_q;
    assign f_valid     = f_q.valid;
    assign f_pc        = f_q.pc;
    assign f_raw_instr = f_q.raw_instr;
    assign f_misalign  = f_q.misalign;
endmodule

// File: tb/tb_fetch_stage.sv
// Scoreboard bench for fetch_stage: budgeted memory responder, expected request/instruction queues.
module tb_fetch_stage;
    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        ireq_valid;
    logic [63:0] ireq_addr;
    logic        iresp_data_ok = 1'b0;
    logic [31:0] iresp_data = '0;
    logic        redirect_valid = 1'b0;
    logic [63:0] redirect_pc = '0;
    logic        d_ready = 1'b0;
    logic        f_valid;
    logic [63:0] f_pc;
    logic [31:0] f_raw_instr;
    logic        f_misalign;

    typedef struct {
        logic [63:0] pc;
        logic [31:0] instr;
    } item_t;

    item_t       exp_q[$];
    logic [63:0] addr_q[$];
    int          total = 0;
    int          bad = 0;
    int          mem_lat = 1;
    int          mem_cnt = 0;
    int          budget = 0;
    bit          rdy = 1'b1;

    fetch_stage dut (
        .clk            (clk),
        .reset          (reset),
        .ireq_valid     (ireq_valid),
        .ireq_addr      (ireq_addr),
        .iresp_data_ok  (iresp_data_ok),
        .iresp_data     (iresp_data),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .d_ready        (d_ready),
        .f_valid        (f_valid),
        .f_pc           (f_pc),
        .f_raw_instr    (f_raw_instr),
        .f_misalign     (f_misalign)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [63:0] a);
        if (a == 64'h8000_0000) return 32'h0000_0013;
        if (a == 64'h8000_0004) return 32'h00a0_0093;
        return a[31:0] ^ 32'h5A5A_0000;
    endfunction

    function automatic item_t mk(input logic [63:0] a);
        item_t it;
        it.pc    = a;
        it.instr = mem_word(a);
        return it;
    endfunction

    // Advance one cycle, then drive this cycle's inputs; DUT outputs are stable on return.
    task automatic tick(input bit redir, input logic [63:0] rpc);
        @(posedge clk);
        #2;
        if (ireq_valid && budget > 0) begin
            if (mem_cnt >= mem_lat) begin
                iresp_data_ok = 1'b1;
                iresp_data    = mem_word(ireq_addr);
                mem_cnt       = 0;
                budget        = budget - 1;
            end else begin
                iresp_data_ok = 1'b0;
                iresp_data    = $urandom;
                mem_cnt       = mem_cnt + 1;
            end
        end else begin
            iresp_data_ok = 1'b0;
            iresp_data    = $urandom;
            mem_cnt       = 0;
        end
        d_ready        = rdy;
        redirect_valid = redir;
        redirect_pc    = rpc;
    endtask

    task automatic scoreboard_mon();
        logic [63:0] ea;
        item_t       ei;
        forever begin
            @(negedge clk);
            if (reset) begin
                if (ireq_valid && iresp_data_ok) begin
                    total++;
                    if (addr_q.size() == 0) begin
                        bad++;
                        $display("FAIL req_addr: got %h, required no request", ireq_addr);
                    end else begin
                        ea = addr_q.pop_front();
                        if (ireq_addr !== ea) begin
                            bad++;
                            $display("FAIL req_addr: got %h, required %h", ireq_addr, ea);
                        end
                    end
                end
                if (f_valid && d_ready && !redirect_valid) begin
                    total++;
                    if (exp_q.size() == 0) begin
                        bad++;
                        $display("FAIL instr_out: got pc=%h instr=%h, required nothing", f_pc, f_raw_instr);
                    end else begin
                        ei = exp_q.pop_front();
                        if (f_pc !== ei.pc || f_raw_instr !== ei.instr) begin
                            bad++;
                            $display("FAIL instr_out: got pc=%h instr=%h, required pc=%h instr=%h",
                                     f_pc, f_raw_instr, ei.pc, ei.instr);
                        end
                    end
                end
            end
        end
    endtask

    task automatic wait_drained(input string name, input int limit);
        for (int i = 0; i < limit && exp_q.size() != 0; i++) tick(1'b0, '0);
        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL %s_timeout: got %0d pending, required 0", name, exp_q.size());
        end
    endtask

    task automatic test_reset();
        repeat (2) @(negedge clk);
        total++; if (ireq_valid !== 1'b0) begin bad++; $display("FAIL rst_ireq_valid: got %b, required 0", ireq_valid); end
        total++; if (ireq_addr !== 64'h8000_0000) begin bad++; $display("FAIL rst_ireq_addr: got %h, required 80000000", ireq_addr); end
        total++; if (f_valid !== 1'b0) begin bad++; $display("FAIL rst_f_valid: got %b, required 0", f_valid); end
        total++; if (f_pc !== 64'h0) begin bad++; $display("FAIL rst_f_pc: got %h, required 0", f_pc); end
        total++; if (f_raw_instr !== 32'h0) begin bad++; $display("FAIL rst_f_raw: got %h, required 0", f_raw_instr); end
        total++; if (f_misalign !== 1'b0) begin bad++; $display("FAIL rst_f_misalign: got %b, required 0", f_misalign); end
        @(posedge clk);
        #2;
        reset   = 1'b1;
        d_ready = rdy;
    endtask

    task automatic test_stream();
        mem_lat = 1;
        budget  = 2;
        addr_q.push_back(64'h8000_0000); exp_q.push_back(mk(64'h8000_0000));
        addr_q.push_back(64'h8000_0004); exp_q.push_back(mk(64'h8000_0004));
        tick(1'b0, '0);
        total++;
        if (ireq_valid !== 1'b1 || ireq_addr !== 64'h8000_0000) begin
            bad++;
            $display("FAIL first_req: got valid=%b addr=%h, required valid=1 addr=80000000", ireq_valid, ireq_addr);
        end
        wait_drained("stream", 40);
    endtask

    task automatic test_stall();
        logic [63:0] held_pc;
        logic [31:0] held_in;
        budget = 1;
        rdy    = 1'b0;
        addr_q.push_back(64'h8000_0008); exp_q.push_back(mk(64'h8000_0008));
        for (int i = 0; i < 20 && f_valid !== 1'b1; i++) tick(1'b0, '0);
        held_pc = 64'h8000_0008;
        held_in = mem_word(64'h8000_0008);
        for (int i = 0; i < 5; i++) begin
            tick(1'b0, '0);
            total++;
            if (f_valid !== 1'b1 || f_pc !== held_pc || f_raw_instr !== held_in || ireq_valid !== 1'b0) begin
                bad++;
                $display("FAIL stall_hold: got v=%b pc=%h instr=%h req=%b, required v=1 pc=%h instr=%h req=0",
                         f_valid, f_pc, f_raw_instr, ireq_valid, held_pc, held_in);
            end
        end
        rdy = 1'b1;
        tick(1'b0, '0);
        tick(1'b0, '0);
        total++;
        if (ireq_valid !== 1'b1 || ireq_addr !== 64'h8000_000C || f_valid !== 1'b0) begin
            bad++;
            $display("FAIL stall_resume: got req=%b addr=%h fv=%b, required req=1 addr=8000000c fv=0",
                     ireq_valid, ireq_addr, f_valid);
        end
        total++;
        if (exp_q.size() != 0) begin bad++; $display("FAIL stall_consume: got %0d pending, required 0", exp_q.size()); end
    endtask

    task automatic test_back_to_back();
        mem_lat = 0;
        budget  = 4;
        for (int k = 0; k < 4; k++) begin
            addr_q.push_back(64'h8000_000C + 64'(4 * k));
            exp_q.push_back(mk(64'h8000_000C + 64'(4 * k)));
        end
        for (int i = 0; i < 10 && f_valid !== 1'b1; i++) tick(1'b0, '0);
        for (int k = 0; k < 6; k++) begin
            total++;
            if (f_valid !== ((k % 2) == 0)) begin
                bad++;
                $display("FAIL b2b_cadence[%0d]: got f_valid=%b, required %b", k, f_valid, (k % 2) == 0);
            end
            tick(1'b0, '0);
        end
        wait_drained("b2b", 20);
    endtask

    task automatic test_redirect_drain();
        mem_lat = 3;
        tick(1'b1, 64'h8000_1000);
        budget = 2;
        addr_q.push_back(64'h8000_001C);
        addr_q.push_back(64'h8000_1000); exp_q.push_back(mk(64'h8000_1000));
        for (int i = 0; i < 3; i++) begin
            tick(1'b0, '0);
            total++;
            if (ireq_valid !== 1'b1 || ireq_addr !== 64'h8000_001C || f_valid !== 1'b0) begin
                bad++;
                $display("FAIL drain_hold[%0d]: got req=%b addr=%h fv=%b, required req=1 addr=8000001c fv=0",
                         i, ireq_valid, ireq_addr, f_valid);
            end
        end
        wait_drained("drain", 30);
    endtask

    task automatic test_redirect_same_cycle();
        mem_lat = 1;
        budget  = 1;
        addr_q.push_back(64'h8000_1004);
        tick(1'b0, '0);
        tick(1'b1, 64'h8000_2000);
        tick(1'b0, '0);
        total++;
        if (ireq_valid !== 1'b1 || ireq_addr !== 64'h8000_2000 || f_valid !== 1'b0) begin
            bad++;
            $display("FAIL same_cycle_redir: got req=%b addr=%h fv=%b, required req=1 addr=80002000 fv=0",
                     ireq_valid, ireq_addr, f_valid);
        end
        budget = 1;
        addr_q.push_back(64'h8000_2000); exp_q.push_back(mk(64'h8000_2000));
        wait_drained("same_cycle", 20);
    endtask

    task automatic test_redirect_hold();
        budget = 1;
        rdy    = 1'b0;
        addr_q.push_back(64'h8000_2004);
        for (int i = 0; i < 20 && f_valid !== 1'b1; i++) tick(1'b0, '0);
        rdy = 1'b1;
        tick(1'b1, 64'h8000_3000);
        tick(1'b0, '0);
        total++;
        if (f_valid !== 1'b0 || ireq_valid !== 1'b1 || ireq_addr !== 64'h8000_3000) begin
            bad++;
            $display("FAIL hold_redir: got fv=%b req=%b addr=%h, required fv=0 req=1 addr=80003000",
                     f_valid, ireq_valid, ireq_addr);
        end
    endtask

    task automatic test_reset_in_drain();
        tick(1'b1, 64'h8000_4000);
        tick(1'b0, '0);
        total++;
        if (ireq_valid !== 1'b1 || ireq_addr !== 64'h8000_3000) begin
            bad++;
            $display("FAIL drain_entry: got req=%b addr=%h, required req=1 addr=80003000", ireq_valid, ireq_addr);
        end
        reset = 1'b0;
        #1;
        total++;
        if (ireq_valid !== 1'b0 || ireq_addr !== 64'h8000_0000 || f_valid !== 1'b0 ||
            f_pc !== 64'h0 || f_raw_instr !== 32'h0 || f_misalign !== 1'b0) begin
            bad++;
            $display("FAIL midreset: got req=%b addr=%h fv=%b pc=%h instr=%h mis=%b, required 0 80000000 0 0 0 0",
                     ireq_valid, ireq_addr, f_valid, f_pc, f_raw_instr, f_misalign);
        end
        redirect_valid = 1'b0;
        @(posedge clk);
        #2;
        reset         = 1'b1;
        iresp_data_ok = 1'b1;
        iresp_data    = 32'hDEAD_BEEF;
        mem_cnt       = 0;
        tick(1'b0, '0);
        total++;
        if (ireq_valid !== 1'b1 || ireq_addr !== 64'h8000_0000 || f_valid !== 1'b0) begin
            bad++;
            $display("FAIL post_reset_req: got req=%b addr=%h fv=%b, required req=1 addr=80000000 fv=0",
                     ireq_valid, ireq_addr, f_valid);
        end
        mem_lat = 1;
        budget  = 1;
        addr_q.push_back(64'h8000_0000); exp_q.push_back(mk(64'h8000_0000));
        wait_drained("post_reset", 20);
    endtask

`ifdef FETCH_ALIGN_CHECK_EN
    task automatic test_misalign();
        bit bus_seen = 1'b0;
        rdy = 1'b0;
        tick(1'b1, 64'h8000_0002);
        budget = 1;
        addr_q.push_back(64'h8000_0004);
        for (int i = 0; i < 20 && f_valid !== 1'b1; i++) begin
            tick(1'b0, '0);
            if (ireq_valid && ireq_addr == 64'h8000_0002) bus_seen = 1'b1;
        end
        total++;
        if (bus_seen) begin bad++; $display("FAIL misalign_req: got a request for 80000002, required none"); end
        total++;
        if (f_valid !== 1'b1 || f_misalign !== 1'b1 || f_raw_instr !== 32'h0000_0013 || f_pc !== 64'h8000_0002) begin
            bad++;
            $display("FAIL misalign_out: got v=%b mis=%b instr=%h pc=%h, required 1 1 00000013 80000002",
                     f_valid, f_misalign, f_raw_instr, f_pc);
        end
        tick(1'b1, 64'h8000_0100);
        tick(1'b0, '0);
        rdy = 1'b1;
    endtask
`endif

    initial begin
        #200000;
        $display("FAIL watchdog: got no completion, required finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        fork
            scoreboard_mon();
        join_none
        test_reset();
        test_stream();
        test_stall();
        test_back_to_back();
        test_redirect_drain();
        test_redirect_same_cycle();
        test_redirect_hold();
        test_reset_in_drain();
`ifdef FETCH_ALIGN_CHECK_EN
        test_misalign();
`endif
        tick(1'b0, '0);
        total++;
        if (addr_q.size() != 0 || exp_q.size() != 0) begin
            bad++;
            $display("FAIL leftover: got addr=%0d instr=%0d pending, required 0 0", addr_q.size(), exp_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
